mips_decode_alu_cp0: RTL and testbench

- Single-cycle MIPS-subset core slice combining three functions: instruction decode (control unit), the 32-bit ALU, and coprocessor 0 for interrupts and ERET.
- Sits between the register file/immediate muxes and the PC/writeback logic.
- Decode and ALU are combinational; CP0 state is clocked.

---
 rtl/mips_decode_alu_cp0_pkg.sv | 105 ++++++++++
 rtl/mips_decode_alu_cp0_if.sv | 43 ++++
 rtl/mips_decode_alu_cp0_alu.sv | 41 ++++
 rtl/mips_decode_alu_cp0.sv | 211 +++++++++++++++++++++
 tb/tb_mips_decode_alu_cp0.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_decode_alu_cp0_pkg.sv
// Shared constants for the decode/ALU/CP0 slice: ALU op codes, MIPS opcode and
// funct values, CP0 register indices and the decoded control-flag bundle.
package mips_decode_alu_cp0_pkg;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ERET    = 6'h18;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RS_MFC0 = 5'h00;
  localparam logic [4:0] RS_MTC0 = 5'h04;
  localparam logic [4:0] RS_CO   = 5'h10;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] STATUS_RST = 32'h0000_000F;

  localparam logic [31:0] VEC0_DEF = 32'h0000_1000;
  localparam logic [31:0] VEC1_DEF = 32'h0000_1100;
  localparam logic [31:0] VEC2_DEF = 32'h0000_1200;

  // Class of an R-type funct; selects which flag group applies.
  typedef enum logic [2:0] {
    RK_NONE,
    RK_SHIFT,
    RK_ALU,
    RK_JR,
    RK_SYSCALL
  } rkind_e;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic bne_or_beq;
    logic jump;
    logic is_jr;
    logic is_jal;
    logic is_shamt;
    logic is_syscall;
    logic zero_extend;
    logic is_cop0;
    logic read_rs;
    logic read_rt;
  } ctrl_t;

  // One-hot of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [2:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (v[0])      r = 3'b001;
    else if (v[1]) r = 3'b010;
    else if (v[2]) r = 3'b100;
    return r;
  endfunction

endpackage

// File: rtl/mips_decode_alu_cp0_if.sv
// Bus bundle between the decode/ALU/CP0 slice (slave) and the surrounding
// datapath (master).
interface mips_decode_alu_cp0_if;
  logic [31:0] instr;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [31:0] pc_in;
  logic [31:0] cp0_din;
  logic [2:0]  exp_src;

  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        equal;

  logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic branch, bne_or_beq, jump, is_jr, is_jal, is_shamt, is_syscall;
  logic zero_extend, is_cop0, read_rs, read_rt;

  logic        has_exp;
  logic        is_eret;
  logic        ex_reg_write;
  logic        exp_block;
  logic [31:0] cp0_pcout;
  logic [31:0] cp0_dout;

  modport slave (
    input  instr, alu_x, alu_y, pc_in, cp0_din, exp_src,
    output alu_op, alu_result, equal,
    output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
    output branch, bne_or_beq, jump, is_jr, is_jal, is_shamt, is_syscall,
    output zero_extend, is_cop0, read_rs, read_rt,
    output has_exp, is_eret, ex_reg_write, exp_block, cp0_pcout, cp0_dout
  );

  modport master (
    output instr, alu_x, alu_y, pc_in, cp0_din, exp_src,
    input  alu_op, alu_result, equal,
    input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
    input  branch, bne_or_beq, jump, is_jr, is_jal, is_shamt, is_syscall,
    input  zero_extend, is_cop0, read_rs, read_rt,
    input  has_exp, is_eret, ex_reg_write, exp_block, cp0_pcout, cp0_dout
  );
endinterface

// File: rtl/mips_decode_alu_cp0_alu.sv
// Combinational 32-bit ALU. ALU_MULDIV_EN enables MUL/DIV on ops 3/4;
// otherwise those ops, like 13-15, return 0.
module mips_alu
  import mips_decode_alu_cp0_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] result_o,
  output logic        equal_o
);

  logic [4:0] sh;
  assign sh      = y_i[4:0];
  assign equal_o = (x_i == y_i);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    result_o = 32'd0;
    case (op_i)
      ALU_SLL:  result_o = x_i << sh;
      ALU_SRA:  result_o = 32'($signed(x_i) >>> sh);
      ALU_SRL:  result_o = x_i >> sh;
`ifdef ALU_MULDIV_EN
      ALU_MUL:  result_o = x_i * y_i;
      ALU_DIV:  result_o = (y_i == 32'd0) ? 32'd0 : 32'($signed(x_i) / $signed(y_i));
`endif
      ALU_ADD:  result_o = x_i + y_i;
      ALU_SUB:  result_o = x_i - y_i;
      ALU_AND:  result_o = x_i & y_i;
      ALU_OR:   result_o = x_i | y_i;
      ALU_XOR:  result_o = x_i ^ y_i;
      ALU_NOR:  result_o = ~(x_i | y_i);
      ALU_SLT:  result_o = {31'd0, $signed(x_i) < $signed(y_i)};
      ALU_SLTU: result_o = {31'd0, x_i < y_i};
      default:  result_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_decode_alu_cp0.sv
// Single-cycle MIPS slice: instruction decode, ALU and CP0 (Status/Cause/EPC,
// three prioritised interrupt sources, ERET). ALU_MULDIV_EN enables MUL/DIV.
module mips_decode_alu_cp0
  import mips_decode_alu_cp0_pkg::*;
#(
  parameter logic [31:0] VEC0 = VEC0_DEF,
  parameter logic [31:0] VEC1 = VEC1_DEF,
  parameter logic [31:0] VEC2 = VEC2_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_decode_alu_cp0_if.slave    bus
);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rd;
  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rd     = bus.instr[15:11];
  assign funct  = bus.instr[5:0];

  ctrl_t      ctrl;
  logic [3:0] alu_op;
  rkind_e     rkind;

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    rkind  = RK_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:          begin alu_op = ALU_SLL;  rkind = RK_SHIFT; end
          FN_SRA:          begin alu_op = ALU_SRA;  rkind = RK_SHIFT; end
          FN_SRL:          begin alu_op = ALU_SRL;  rkind = RK_SHIFT; end
          FN_ADD, FN_ADDU: begin alu_op = ALU_ADD;  rkind = RK_ALU;   end
          FN_SUB, FN_SUBU: begin alu_op = ALU_SUB;  rkind = RK_ALU;   end
          FN_AND:          begin alu_op = ALU_AND;  rkind = RK_ALU;   end
          FN_OR:           begin alu_op = ALU_OR;   rkind = RK_ALU;   end
          FN_XOR:          begin alu_op = ALU_XOR;  rkind = RK_ALU;   end
          FN_NOR:          begin alu_op = ALU_NOR;  rkind = RK_ALU;   end
          FN_SLT:          begin alu_op = ALU_SLT;  rkind = RK_ALU;   end
          FN_SLTU:         begin alu_op = ALU_SLTU; rkind = RK_ALU;   end
          FN_JR:           rkind = RK_JR;
          FN_SYSCALL:      rkind = RK_SYSCALL;
          default:         rkind = RK_NONE;
        endcase
        // Shifts take rt as x and shamt as y, so rs is not read.
        ctrl.reg_dst    = (rkind != RK_NONE);
        ctrl.reg_write  = (rkind == RK_SHIFT) || (rkind == RK_ALU);
        ctrl.is_shamt   = (rkind == RK_SHIFT);
        ctrl.is_jr      = (rkind == RK_JR);
        ctrl.is_syscall = (rkind == RK_SYSCALL);
        ctrl.read_rs    = (rkind == RK_ALU) || (rkind == RK_JR);
        ctrl.read_rt    = (rkind == RK_ALU) || (rkind == RK_SHIFT);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.read_rs   = 1'b1;
        case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI:  alu_op = ALU_AND;
          OP_ORI:   alu_op = ALU_OR;
          OP_XORI:  alu_op = ALU_XOR;
          default:  alu_op = ALU_ADD;
        endcase
        ctrl.zero_extend = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
      end
      OP_LW: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.read_rs    = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.read_rs   = 1'b1;
        ctrl.read_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu_op          = ALU_SUB;
        ctrl.branch     = 1'b1;
        ctrl.bne_or_beq = (opcode == OP_BEQ);
        ctrl.read_rs    = 1'b1;
        ctrl.read_rt    = 1'b1;
      end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.is_jal    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_COP0: begin
        ctrl.is_cop0 = 1'b1;
        ctrl.read_rt = (rs == RS_MTC0);
      end
      default: ;
    endcase
  end

  mips_alu u_alu (
    .op_i     (alu_op),
    .x_i      (bus.alu_x),
    .y_i      (bus.alu_y),
    .result_o (bus.alu_result),
    .equal_o  (bus.equal)
  );

  assign bus.alu_op      = alu_op;
  assign bus.reg_dst     = ctrl.reg_dst;
  assign bus.alu_src     = ctrl.alu_src;
  assign bus.mem_to_reg  = ctrl.mem_to_reg;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.mem_read    = ctrl.mem_read;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.branch      = ctrl.branch;
  assign bus.bne_or_beq  = ctrl.bne_or_beq;
  assign bus.jump        = ctrl.jump;
  assign bus.is_jr       = ctrl.is_jr;
  assign bus.is_jal      = ctrl.is_jal;
  assign bus.is_shamt    = ctrl.is_shamt;
  assign bus.is_syscall  = ctrl.is_syscall;
  assign bus.zero_extend = ctrl.zero_extend;
  assign bus.is_cop0     = ctrl.is_cop0;
  assign bus.read_rs     = ctrl.read_rs;
  assign bus.read_rt     = ctrl.read_rt;

  logic is_mfc0, is_mtc0, is_eret;
  assign is_mfc0 = ctrl.is_cop0 && (rs == RS_MFC0);
  assign is_mtc0 = ctrl.is_cop0 && (rs == RS_MTC0);
  assign is_eret = ctrl.is_cop0 && (rs == RS_CO) && (funct == FN_ERET);

  logic [31:0] status_q, status_d;
  logic [2:0]  cause_q,  cause_d;
  logic [31:0] epc_q,    epc_d;

  logic [2:0]  pend_en, take;
  logic        has_exp;
  logic [31:0] vec;
  logic [31:0] rd_data;

  assign pend_en = cause_q & status_q[3:1];
  assign has_exp = status_q[0] && (|pend_en) && !is_eret;
  assign take    = lowest_set(pend_en);

  always_comb begin
    vec = VEC2;
    if (take[0])      vec = VEC0;
    else if (take[1]) vec = VEC1;
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd)
      CP0_STATUS: rd_data = status_q;
      CP0_CAUSE:  rd_data = {29'd0, cause_q};
      CP0_EPC:    rd_data = epc_q;
      default:    rd_data = 32'd0;
    endcase
  end

  // Priority, lowest to highest: MTC0, pending latch, ERET, exception entry.
  // Later assignments override, so the exception's IE clear beats an MTC0 to
  // Status and clearing the taken source beats re-latching it.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (is_mtc0) begin
      case (rd)
        CP0_STATUS: status_d = bus.cp0_din;
        CP0_CAUSE:  cause_d  = bus.cp0_din[2:0];
        CP0_EPC:    epc_d    = bus.cp0_din;
        default: ;
      endcase
    end
    cause_d = cause_d | bus.exp_src;
    if (is_eret) status_d[0] = 1'b1;
    if (has_exp) begin
      status_d[0] = 1'b0;
      epc_d       = bus.pc_in;
      cause_d     = cause_d & ~take;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= STATUS_RST;
      cause_q  <= 3'd0;
      epc_q    <= 32'd0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  assign bus.has_exp      = has_exp;
  assign bus.is_eret      = is_eret;
  assign bus.ex_reg_write = is_mfc0;
  assign bus.exp_block    = ~status_q[0];
  assign bus.cp0_pcout    = has_exp ? vec : epc_q;
  assign bus.cp0_dout     = is_mfc0 ? rd_data : 32'd0;

endmodule

// File: tb/tb_mips_decode_alu_cp0.sv
// Self-checking bench: directed scenarios plus randomized instructions, all
// compared against a behavioural model of decode, ALU and CP0.
`timescale 1ns/1ps
module tb_mips_decode_alu_cp0;

  localparam logic [31:0] V0 = 32'h0000_1000;
  localparam logic [31:0] V1 = 32'h0000_1100;
  localparam logic [31:0] V2 = 32'h0000_1200;

  localparam logic [16:0] F_RDST = 17'h10000, F_ASRC = 17'h08000, F_M2R = 17'h04000;
  localparam logic [16:0] F_RW   = 17'h02000, F_MRD  = 17'h01000, F_MWR = 17'h00800;
  localparam logic [16:0] F_BR   = 17'h00400, F_BEQ  = 17'h00200, F_J   = 17'h00100;
  localparam logic [16:0] F_JR   = 17'h00080, F_JAL  = 17'h00040, F_SH  = 17'h00020;
  localparam logic [16:0] F_SYS  = 17'h00010, F_ZX   = 17'h00008, F_C0  = 17'h00004;
  localparam logic [16:0] F_RS   = 17'h00002, F_RT   = 17'h00001;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_decode_alu_cp0_if bus();

  mips_decode_alu_cp0 #(.VEC0(V0), .VEC1(V1), .VEC2(V2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [16:0] dut_flags;
  assign dut_flags = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write,
                      bus.mem_read, bus.mem_write, bus.branch, bus.bne_or_beq,
                      bus.jump, bus.is_jr, bus.is_jal, bus.is_shamt, bus.is_syscall,
                      bus.zero_extend, bus.is_cop0, bus.read_rs, bus.read_rt};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // CP0 architectural state and the next-state computed for the coming edge.
  logic [31:0] m_status, m_epc, n_status, n_epc;
  logic [2:0]  m_cause, n_cause;

  task automatic model_reset();
    m_status = 32'hF; m_cause = 3'd0; m_epc = 32'd0;
    n_status = 32'hF; n_cause = 3'd0; n_epc = 32'd0;
  endtask

  function automatic void model_decode(input logic [31:0] ins, output logic [16:0] f,
                                       output logic [3:0] a);
    logic [5:0] op, fn;
    logic [4:0] rs;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21];
    f = '0; a = 4'd5;
    if (op == 6'h00) begin
      case (fn)
        6'h00:        begin a = 4'd0;  f = F_RDST | F_RW | F_SH | F_RT; end
        6'h03:        begin a = 4'd1;  f = F_RDST | F_RW | F_SH | F_RT; end
        6'h02:        begin a = 4'd2;  f = F_RDST | F_RW | F_SH | F_RT; end
        6'h20, 6'h21: begin a = 4'd5;  f = F_RDST | F_RW | F_RS | F_RT; end
        6'h22, 6'h23: begin a = 4'd6;  f = F_RDST | F_RW | F_RS | F_RT; end
        6'h24:        begin a = 4'd7;  f = F_RDST | F_RW | F_RS | F_RT; end
        6'h25:        begin a = 4'd8;  f = F_RDST | F_RW | F_RS | F_RT; end
        6'h26:        begin a = 4'd9;  f = F_RDST | F_RW | F_RS | F_RT; end
        6'h27:        begin a = 4'd10; f = F_RDST | F_RW | F_RS | F_RT; end
        6'h2A:        begin a = 4'd11; f = F_RDST | F_RW | F_RS | F_RT; end
        6'h2B:        begin a = 4'd12; f = F_RDST | F_RW | F_RS | F_RT; end
        6'h08:        f = F_RDST | F_JR | F_RS;
        6'h0C:        f = F_RDST | F_SYS;
        default: ;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin a = 4'd5;  f = F_ASRC | F_RW | F_RS; end
        6'h0A:        begin a = 4'd11; f = F_ASRC | F_RW | F_RS; end
        6'h0B:        begin a = 4'd12; f = F_ASRC | F_RW | F_RS; end
        6'h0C:        begin a = 4'd7;  f = F_ASRC | F_RW | F_RS | F_ZX; end
        6'h0D:        begin a = 4'd8;  f = F_ASRC | F_RW | F_RS | F_ZX; end
        6'h0E:        begin a = 4'd9;  f = F_ASRC | F_RW | F_RS | F_ZX; end
        6'h23:        f = F_MRD | F_M2R | F_ASRC | F_RW | F_RS;
        6'h2B:        f = F_MWR | F_ASRC | F_RS | F_RT;
        6'h04:        begin a = 4'd6; f = F_BR | F_BEQ | F_RS | F_RT; end
        6'h05:        begin a = 4'd6; f = F_BR | F_RS | F_RT; end
        6'h02:        f = F_J;
        6'h03:        f = F_J | F_JAL | F_RW;
        6'h10:        f = (rs == 5'h04) ? (F_C0 | F_RT) : F_C0;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] a, input logic [31:0] x,
                                            input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (a)
      4'd0:  return x << sh;
      4'd1:  return 32'($signed(x) >>> sh);
      4'd2:  return x >> sh;
`ifdef ALU_MULDIV_EN
      4'd3:  return x * y;
      4'd4:  return (y == 0) ? 32'd0 : 32'($signed(x) / $signed(y));
`endif
      4'd5:  return x + y;
      4'd6:  return x - y;
      4'd7:  return x & y;
      4'd8:  return x | y;
      4'd9:  return x ^ y;
      4'd10: return ~(x | y);
      4'd11: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one instruction, compare every output against the model and
  // prepare the model's post-edge CP0 state.
  task automatic drive(input logic [31:0] ins, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] pc, input logic [31:0] din, input logic [2:0] src);
    logic [16:0] ef;
    logic [3:0]  ea;
    logic [4:0]  rs, rd;
    logic        cop, mf, mt, er, hx;
    logic [2:0]  pend;
    logic [31:0] vec, rdval;
    int          src_idx;
    bus.instr = ins; bus.alu_x = x; bus.alu_y = y;
    bus.pc_in = pc;  bus.cp0_din = din; bus.exp_src = src;
    #2;
    model_decode(ins, ef, ea);
    check("alu_op", 32'(bus.alu_op), 32'(ea));
    check("flags", 32'(dut_flags), 32'(ef));
    check("alu_result", bus.alu_result, model_alu(ea, x, y));
    check("equal", 32'(bus.equal), (x == y) ? 32'd1 : 32'd0);

    rs = ins[25:21]; rd = ins[15:11];
    cop = (ins[31:26] == 6'h10);
    mf  = cop && (rs == 5'h00);
    mt  = cop && (rs == 5'h04);
    er  = cop && (rs == 5'h10) && (ins[5:0] == 6'h18);
    pend = m_cause & m_status[3:1];
    hx   = m_status[0] && (pend != 3'd0) && !er;
    src_idx = pend[0] ? 0 : (pend[1] ? 1 : 2);
    vec  = (src_idx == 0) ? V0 : ((src_idx == 1) ? V1 : V2);
    rdval = (rd == 5'd12) ? m_status :
            (rd == 5'd13) ? {29'd0, m_cause} :
            (rd == 5'd14) ? m_epc : 32'd0;

    check("has_exp", 32'(bus.has_exp), 32'(hx));
    check("is_eret", 32'(bus.is_eret), 32'(er));
    check("ex_reg_write", 32'(bus.ex_reg_write), 32'(mf));
    check("exp_block", 32'(bus.exp_block), 32'(!m_status[0]));
    check("cp0_pcout", bus.cp0_pcout, hx ? vec : m_epc);
    check("cp0_dout", bus.cp0_dout, mf ? rdval : 32'd0);

    n_status = m_status; n_cause = m_cause; n_epc = m_epc;
    if (mt && rd == 5'd12) n_status = din;
    if (mt && rd == 5'd13) n_cause  = din[2:0];
    if (mt && rd == 5'd14) n_epc    = din;
    n_cause = n_cause | src;
    if (er) n_status[0] = 1'b1;
    if (hx) begin
      n_status[0]      = 1'b0;
      n_epc            = pc;
      n_cause[src_idx] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    #1;
  endtask

  logic [5:0] r_fn  [15] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h0C};
  logic [5:0] i_op  [13] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                             6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] u_op  [7]  = '{6'h01, 6'h06, 6'h07, 6'h0F, 6'h11, 6'h20, 6'h3F};
  logic [4:0] c0_rd [4]  = '{5'd12, 5'd13, 5'd14, 5'd7};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin r[31:26] = 6'h00; r[5:0] = r_fn[$urandom_range(0, 14)]; end
      3, 4, 5: r[31:26] = i_op[$urandom_range(0, 12)];
      6: begin
        r[31:26] = 6'h10;
        r[25:21] = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'h04;
        r[15:11] = c0_rd[$urandom_range(0, 3)];
      end
      7: r = 32'h4200_0018;
      8: r[31:26] = u_op[$urandom_range(0, 6)];
      default: r[31:26] = 6'h10;
    endcase
    return r;
  endfunction

  initial begin
    model_reset();
    #1 reset = 1'b0;
    drive(32'h4004_6000, 0, 0, 0, 0, 3'b000);
    check("rst_status", bus.cp0_dout, 32'h0000_000F);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    drive(32'h0022_1822, 32'd7, 32'd5, 0, 0, 3'b000);
    check("sub_result", bus.alu_result, 32'd2);
    check("sub_equal", 32'(bus.equal), 32'd0);
    tick();
    drive(32'h0022_182A, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'b000);
    check("slt_neg", bus.alu_result, 32'd1);
    tick();
    drive(32'h0022_182B, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'b000);
    check("sltu_neg", bus.alu_result, 32'd0);
    tick();
    drive(32'h0085_1020, 32'd3, 32'd4, 0, 0, 3'b000);
    check("add_reg_dst", 32'(bus.reg_dst), 32'd1);
    check("add_alu_op", 32'(bus.alu_op), 32'd5);
    tick();
    drive(32'h8C88_0004, 32'h100, 32'h4, 0, 0, 3'b000);
    check("lw_mem_read", 32'(bus.mem_read), 32'd1);
    check("lw_alu_src", 32'(bus.alu_src), 32'd1);
    tick();

    // IE off, latch source 1, read Cause back through MFC0.
    drive(32'h4080_6000, 0, 0, 0, 32'h0000_000E, 3'b000); tick();
    drive(32'h0000_0000, 0, 0, 0, 0, 3'b010); tick();
    drive(32'h4004_6800, 0, 0, 0, 0, 3'b000);
    check("mfc0_cause", bus.cp0_dout, 32'd2);
    check("mfc0_exwr", 32'(bus.ex_reg_write), 32'd1);
    tick();

    // Re-enable IE: source 1 wins over 2, EPC captures pc_in.
    drive(32'h4080_6000, 0, 0, 0, 32'h0000_000F, 3'b000); tick();
    drive(32'h0000_0000, 0, 0, 32'h40, 0, 3'b110);
    check("irq_has_exp", 32'(bus.has_exp), 32'd1);
    check("irq_vec1", bus.cp0_pcout, V1);
    tick();
    drive(32'h4004_6800, 0, 0, 0, 0, 3'b000);
    check("cause_after", bus.cp0_dout, 32'd4);
    check("blocked", 32'(bus.exp_block), 32'd1);
    drive(32'h4004_7000, 0, 0, 0, 0, 3'b000);
    check("epc_after", bus.cp0_dout, 32'h40);
    drive(32'h4200_0018, 0, 0, 32'h44, 0, 3'b000);
    check("eret_pc", bus.cp0_pcout, 32'h40);
    check("eret_flag", 32'(bus.is_eret), 32'd1);
    tick();
    drive(32'h0000_0000, 0, 0, 32'h80, 0, 3'b000);
    check("irq_vec2", bus.cp0_pcout, V2);
    tick();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins, x, y, pc, din;
      logic [2:0]  src;
      ins = rand_instr();
      x   = $urandom;
      y   = $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 20)) - 32'd10;
      if ($urandom_range(0, 4) == 0) y = x;
      pc  = $urandom & 32'hFFFF_FFFC;
      din = $urandom;
      src = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      drive(ins, x, y, pc, din, src);
      tick();
    end

    // Asynchronous reset asserted between clock edges.
    drive(32'h4080_7000, 0, 0, 0, 32'h0000_1234, 3'b000); tick();
    drive(32'h0000_0000, 0, 0, 0, 0, 3'b101);
    #1 reset = 1'b0;
    model_reset();
    #1;
    drive(32'h4004_7000, 0, 0, 0, 0, 3'b000);
    check("arst_epc", bus.cp0_dout, 32'd0);
    drive(32'h4004_6800, 0, 0, 0, 0, 3'b000);
    check("arst_cause", bus.cp0_dout, 32'd0);
    drive(32'h4004_6000, 0, 0, 0, 0, 3'b000);
    check("arst_status", bus.cp0_dout, 32'h0000_000F);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    drive(32'h0000_0000, 0, 0, 32'h200, 0, 3'b100); tick();
    drive(32'h0000_0000, 0, 0, 32'h204, 0, 3'b000);
    check("post_rst_vec2", bus.cp0_pcout, V2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
